// File: rtl/ln_share_arb.sv
// Round-robin front end for one shared pipelined ln unit.
// Credit-limited issue; results return through a tagged response FIFO.
module ln_share_arb #(
  parameter  int W          = 24,
  parameter  int N_REQ      = 4,
  parameter  int LAT        = 2,
  parameter  int FIFO_DEPTH = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW  = $clog2(FIFO_DEPTH + 1),
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_quant,
  output logic [W-1:0]       ln_a,
  output logic [7:0]         ln_quant,
  input  logic [W-1:0]       ln_z,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_z,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_sentinel,
  output logic               busy
);

  localparam logic [W-1:0] SENT = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);

  function automatic logic [IDW-1:0] rr_idx(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LAT:0]   tag_v_q;
  logic [LAT:0][IDW-1:0] tag_id_q;

  logic [W-1:0]   mem_z_q  [FIFO_DEPTH];
  logic [IDW-1:0] mem_id_q [FIFO_DEPTH];

  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           gnt_any;
  logic           credit_ok;
  logic           issue;
  logic           pop;
  logic           wr_en;
  logic [W-1:0]   op_a;
  logic [7:0]     op_q;

  // Scan from ptr upward, wrapping at N_REQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = rr_idx(ptr_q, k);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    op_a = '0;
    op_q = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_a = req_a[i*W +: W];
        op_q = req_quant[i*8 +: 8];
      end
    end
  end

  assign credit_ok = (count_q < DEPTH_C);

  // rst_n gate keeps req_ready low while reset is held.
  assign req_ready = (credit_ok && gnt_any && rst_n)
                   ? (N_REQ'(1) << gnt_idx)
                   : '0;

  assign issue = |(req_valid & req_ready);
  assign pop   = rsp_valid & rsp_ready;
  assign wr_en = tag_v_q[LAT];

  assign ptr_d = issue ? rr_idx(gnt_idx, 1) : ptr_q;

  always_comb begin
    unique case (1'b1)
      issue && !pop: count_d = count_q + 1'b1;
      !issue && pop: count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      wr_en && !pop: occ_d = occ_q + 1'b1;
      !wr_en && pop: occ_d = occ_q - 1'b1;
      default:       occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      count_q  <= '0;
      ln_a     <= '0;
      ln_quant <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (issue) begin
        ln_a     <= op_a;
        ln_quant <= op_q;
      end
      tag_v_q  <= {tag_v_q[LAT-1:0], issue};
      tag_id_q <= {tag_id_q[LAT-1:0], gnt_idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (wr_en) wr_ptr_q <= nxt_ptr(wr_ptr_q);
      if (pop)   rd_ptr_q <= nxt_ptr(rd_ptr_q);
    end
  end

  // Storage needs no reset: reads are masked by occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_z_q[wr_ptr_q]  <= ln_z;
      mem_id_q[wr_ptr_q] <= tag_id_q[LAT];
    end
  end

  assign rsp_valid    = (occ_q != '0);
  assign rsp_z        = rsp_valid ? mem_z_q[rd_ptr_q] : '0;
  assign rsp_id       = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
  assign rsp_sentinel = rsp_valid && (mem_z_q[rd_ptr_q] == SENT);
  assign busy         = (count_q != '0);

  a_count_max: assert property (
    @(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n) !(wr_en && occ_q == DEPTH_C));

  a_ready_1h: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule
